pipe_reg: RTL and testbench

Parametrised pipeline register chain: DEPTH stages of WIDTH-bit data, each with its own valid bit, joined by a valid/ready handshake. It replaces bare D flip-flops between CPU pipeline sections. It adds stall back-pressure, bubble collapsing, a single-cycle flush and an occupancy count. One word enters per cycle and one word leaves per cycle, with fixed latency when downstream never stalls.

---
 rtl/pipe_pkg.sv | 10 +
 rtl/pipe_stage.sv | 49 ++++
 rtl/pipe_reg.sv | 65 ++++++
 tb/tb_pipe_reg.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults and sizing helper for the pipe_reg register chain.
package pipe_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 2;

  // Bits needed to count 0..depth valid stages.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_stage.sv
// One valid+data pipeline stage with ready/valid handshake and flush.
module pipe_stage #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  input  logic             flush,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  // An empty stage accepts regardless of downstream, which closes bubbles.
  assign ready = ~valid_q | dn_ready;
  assign load  = ready & up_valid & ~flush;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = up_data;
    end else if (dn_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VAL;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
endmodule

// File: rtl/pipe_reg.sv
// DEPTH-stage valid/ready register chain with stall, bubble collapse,
// single-cycle flush and occupancy count.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      flush,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);
  localparam int OCC_W = occ_w(DEPTH);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0]            up_v;
  logic [DEPTH-1:0][WIDTH-1:0] up_d;
  // Unpacked so each ripple link is its own signal.
  logic                        rdy [DEPTH+1];

  assign rdy[DEPTH] = out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign up_v[g] = in_valid;
      assign up_d[g] = in_data;
    end else begin : g_body
      assign up_v[g] = v[g-1];
      assign up_d[g] = d[g-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up_valid (up_v[g]),
      .up_data  (up_d[g]),
      .dn_ready (rdy[g+1]),
      .flush    (flush),
      .valid    (v[g]),
      .data     (d[g]),
      .ready    (rdy[g])
    );
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out_valid = v[DEPTH-1] & ~flush;
  assign out_data  = d[DEPTH-1];

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(v[i]);
  end
endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg: directed scenarios plus random traffic.
module tb_pipe_reg;
  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             clk, rst;
  logic             in_valid, in_ready, out_valid, out_ready, flush;
  logic [WIDTH-1:0] in_data, out_data;
  logic [OCC_W-1:0] occupancy;

  pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL('0)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flush     (flush),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: words in flight in order, with the cycle they were accepted.
  logic [WIDTH-1:0] exp_q [$];
  int               acc_q [$];
  int               last_stall = 0;
  logic             prev_hold  = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_q.delete();
      prev_hold  = 1'b0;
      last_stall = cyc;
    end else begin
      chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
      chk("in_ready", 32'(in_ready),
          32'(!flush && (exp_q.size() < DEPTH || out_ready)));
      if (flush) chk("out_valid_in_flush", 32'(out_valid), 32'd0);
      if (exp_q.size() == 0) chk("out_valid_when_empty", 32'(out_valid), 32'd0);
      if (prev_hold && !flush) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (!out_ready) last_stall = cyc;
      if (flush) begin
        exp_q.delete();
        acc_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          logic [WIDTH-1:0] e;
          int a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("out_data", 32'(out_data), 32'(e));
          // Never stalled since acceptance: latency must be exactly DEPTH cycles.
          if (a > last_stall) chk("latency", 32'(cyc - a), 32'(DEPTH));
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(in_data);
          acc_q.push_back(cyc);
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic drive(input logic iv, input logic [WIDTH-1:0] dat,
                       input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'h0000);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
    #3;
    reset_checks("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Streaming: latency and gap-free order checked by the monitor.
    drive(1'b1, 16'h1111, 1'b1, 1'b0);
    drive(1'b1, 16'h2222, 1'b1, 1'b0);
    drive(1'b1, 16'h3333, 1'b1, 1'b0);
    drive(1'b1, 16'h4444, 1'b1, 1'b0);
    idle(6, 1'b1);

    // Back-pressure: fill, refuse a 4th word, then drain.
    drive(1'b1, 16'hA001, 1'b0, 1'b0);
    drive(1'b1, 16'hA002, 1'b0, 1'b0);
    drive(1'b1, 16'hA003, 1'b0, 1'b0);
    drive(1'b1, 16'hA004, 1'b0, 1'b0);
    #1;
    chk("bp_occupancy", 32'(occupancy), 32'd3);
    chk("bp_in_ready",  32'(in_ready),  32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_out_data",  32'(out_data),  32'hA001);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    idle(5, 1'b1);

    // Bubble collapse under stall.
    drive(1'b1, 16'hB001, 1'b0, 1'b0);
    drive(1'b0, '0,       1'b0, 1'b0);
    drive(1'b1, 16'hB002, 1'b0, 1'b0);
    idle(2, 1'b0);
    #1;
    chk("bubble_occupancy", 32'(occupancy), 32'd2);
    chk("bubble_out_data",  32'(out_data),  32'hB001);

    // Flush with a word presented on the same cycle.
    drive(1'b1, 16'hC0DE, 1'b0, 1'b1);
    #1;
    chk("flush_in_ready",  32'(in_ready),  32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    drive(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("post_flush_occupancy", 32'(occupancy), 32'd0);
    chk("post_flush_out_valid", 32'(out_valid), 32'd0);
    idle(5, 1'b1);

    // Full chain with simultaneous in/out.
    drive(1'b1, 16'hD001, 1'b0, 1'b0);
    drive(1'b1, 16'hD002, 1'b0, 1'b0);
    drive(1'b1, 16'hD003, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'hD010 + 16'(k), 1'b1, 1'b0);
      #1 chk("full_occupancy", 32'(occupancy), 32'd3);
    end
    idle(6, 1'b1);

    // Asynchronous reset with words in flight.
    drive(1'b1, 16'hE001, 1'b0, 1'b0);
    drive(1'b1, 16'hE002, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 reset_checks("midreset");
    @(posedge clk); #1 rst = 1'b0;
    idle(4, 1'b1);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      drive(($urandom % 4) != 0, WIDTH'($urandom), ($urandom % 3) != 0,
            ($urandom % 25) == 0);
    idle(8, 1'b1);
    #1 chk("final_occupancy", 32'(occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
